// File: rtl/riscv_dmem_responder.sv
// rtl/riscv_dmem_responder.sv - word RAM responder for the LSU with wait states and valid/ready channels
// Optional: define DMEM_MISALIGN_ERR_EN to flag misaligned halfword/word accesses as errors.
module riscv_dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            commit;
  logic            l_we;
  logic [2:0]      l_funct3;
  logic [AW+1:0]   l_addr;
  logic [31:0]     l_wdata;

  logic [31:0]     mem [DEPTH];

  logic            op_we;
  logic [2:0]      op_funct3;
  logic [AW+1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            op_err;
  logic [3:0]      be;
  logic [31:0]     wr_word;
  logic [31:0]     ld_data;

  logic            unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero latency the commit happens on the accepting edge, so decode the live request.
  always_comb begin
    op_we     = (state_q == IDLE) ? req_we : l_we;
    op_funct3 = (state_q == IDLE) ? req_funct3 : l_funct3;
    op_addr   = (state_q == IDLE) ? req_addr[AW+1:0] : l_addr;
    op_wdata  = (state_q == IDLE) ? req_wdata : l_wdata;
    idx       = op_addr[AW+1:2];
    lane      = op_addr[1:0];
    word      = mem[idx];
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = word[{lane[1], 4'b0000} +: 16];
    op_err    = 1'b0;
    be        = 4'b0000;
    wr_word   = op_wdata;
    ld_data   = 32'd0;
    case (op_funct3)
      3'b000, 3'b100: begin
        be      = 4'b0001 << lane;
        wr_word = {4{op_wdata[7:0]}};
        ld_data = op_funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      3'b001, 3'b101: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{op_wdata[15:0]}};
        ld_data = op_funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
`ifdef DMEM_MISALIGN_ERR_EN
        if (lane[0]) op_err = 1'b1;
`endif
      end
      3'b010: begin
        be      = 4'b1111;
        ld_data = word;
`ifdef DMEM_MISALIGN_ERR_EN
        if (lane != 2'b00) op_err = 1'b1;
`endif
      end
      default: op_err = 1'b1;
    endcase
    if (op_funct3[2] && op_we) op_err = 1'b1;
    if (op_err || !op_we) be = 4'b0000;
    if (op_err || op_we) ld_data = 32'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      l_we      <= 1'b0;
      l_funct3  <= 3'd0;
      l_addr    <= '0;
      l_wdata   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        l_we     <= req_we;
        l_funct3 <= req_funct3;
        l_addr   <= req_addr[AW+1:0];
        l_wdata  <= req_wdata;
      end
      if (commit) begin
        rsp_rdata <= ld_data;
        rsp_err   <= op_err;
      end
    end
  end

  // Memory is deliberately outside the reset domain; rst only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (commit && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/riscv_dmem_responder.md
Name: riscv_dmem_responder

Overview:
- Data-memory responder for the riscv_processor load/store port; the processor issues requests, this block accepts them and returns responses.
- Word-organised RAM with byte/half/word access, RISC-V load sign/zero extension, programmable wait states and a valid/ready handshake on both request and response channels.
- Sits between the core's LSU and the data array; replaces the core's zero-latency internal data_mem array for multi-cycle memory modelling.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, minimum 2.
- LATENCY, 2, wait cycles between request acceptance and response; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores.
- rsp_err  out  1  request was illegal; no memory side effect.

Behaviour:
- Reset (rst=0, async): state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not cleared. Reset mid-operation drops the pending request; a store not yet committed is lost.
- One outstanding request. Handshake completes when valid && ready on a rising edge.
- FSM states:
  - IDLE: req_ready=1. On accept, latch we/funct3/addr/wdata. Go to WAIT if LATENCY>0 (counter=LATENCY-1), else go to RESP.
  - WAIT: req_ready=0. Decrement the counter; at 0, go to RESP.
  - RESP: rsp_valid=1 and held, with stable rdata/err, until rsp_ready. On handshake go to IDLE.
  - A request presented in the same cycle as the response handshake is not accepted; it is accepted in the following IDLE cycle.
- Commit: on the transition into RESP, the store is written and the load data captured. Request-to-rsp_valid latency is LATENCY+1 cycles. Back-to-back throughput is one request per LATENCY+2 cycles.
- Indexing: word index = req_addr[2 +: log2(DEPTH)]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Stores:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and +1 with wdata[15:0].
  - SW writes all lanes.
  - Other lanes are unchanged.
- Loads: select the lane(s) as for stores; funct3 000/001 sign-extend, 100/101 zero-extend, 010 returns the full word.
- Illegal funct3 (011, 110, 111, or 100/101 with we=1): rsp_err=1, rsp_rdata=0, no write, same latency as a legal request.
- Store response: rsp_rdata=0.

Optional Feature:
- DMEM_MISALIGN_ERR_EN.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 gives rsp_err=1, rsp_rdata=0, no write.
- Undefined: low address bits are masked instead: halfword uses addr[1] only, word ignores addr[1:0]. rsp_err is set only for illegal funct3.

Test Plan:
- LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
- SB 0x13 data 0x80 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
- SH 0x22 data 0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; addr 0x22 + DEPTH*4 reads the same value (wrap).
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0 throughout; a req_valid held meanwhile is accepted in the cycle after the response handshake.
- Assert rst=0 during WAIT of SW 0x40 data 0x12345678 -> rsp_valid=0 immediately; after release, LW 0x40 returns the prior value 0x00000000.
- funct3=011 -> err=1, rdata=0, memory unchanged. With DMEM_MISALIGN_ERR_EN, LW 0x11 -> err=1; without it, LW 0x11 -> word at 0x10, err=0.
